// File: rtl/mips_multiciclo.sv
// Multi-cycle MIPS subset core: one shared req/ack memory port,
// run/idle control with an RF init port, and a sticky trap on illegal encodings.
module mips_multiciclo #(
  parameter int          RF_DEPTH = 32,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              init_we,
  input  logic [4:0]        init_addr,
  input  logic [31:0]       init_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       pc,
  output logic [31:0]       alu_result,
  output logic              flag_zero,
  output logic [2:0]        state,
  output logic              instr_done,
  output logic              trap
);

  localparam int RW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } st_t;

  st_t               state_q;
  logic [31:0]       pc_q, ir_q, a_q, b_q, sext_q, tgt_q, mdr_q, alu_q;
  logic              zero_q, req_q, we_q, trap_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rf_q [RF_DEPTH];

  logic [5:0]  op, fn;
  logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j, fn_ok, legal;
  logic [31:0] sext_d, alu_d, br_pc_d, nxt_pc_d, rf_wd;
  logic [RW-1:0] rs, rt, rd, rf_wa;
  logic        rf_we, retire;

  assign op      = ir_q[31:26];
  assign fn      = ir_q[5:0];
  assign is_r    = (op == 6'h00);
  assign is_addi = (op == 6'h08);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_j    = (op == 6'h02);
  assign fn_ok   = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  assign legal   = (is_r && fn_ok) || is_addi || is_lw
                || is_sw || is_beq || is_j;

  assign rs     = ir_q[21 +: RW];
  assign rt     = ir_q[16 +: RW];
  assign rd     = ir_q[11 +: RW];
  assign sext_d = {{16{ir_q[15]}}, ir_q[15:0]};

  always_comb begin
    alu_d = a_q + sext_q;
    unique case (1'b1)
      is_beq: alu_d = a_q - b_q;
      is_r: begin
        case (fn)
          6'h22:   alu_d = a_q - b_q;
          6'h24:   alu_d = a_q & b_q;
          6'h25:   alu_d = a_q | b_q;
          6'h2A:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
          default: alu_d = a_q + b_q;
        endcase
      end
      default: ;
    endcase
  end

  assign br_pc_d = is_j ? {pc_q[31:28], ir_q[25:0], 2'b00}
                 : (is_beq && alu_d == 32'd0) ? tgt_q : pc_q;
  assign nxt_pc_d = (state_q == S_EXEC) ? br_pc_d : pc_q;

  // sw retires on the ack itself, so retire is a same-cycle strobe
  assign retire = (state_q == S_WB)
               || (state_q == S_EXEC && (is_beq || is_j))
               || (state_q == S_MEM && mem_ack && is_sw);

  always_comb begin
    rf_we = 1'b0;
    rf_wa = init_addr[RW-1:0];
    rf_wd = init_data;
    if (state_q == S_IDLE) begin
      rf_we = init_we && !run && (init_addr[RW-1:0] != '0);
    end else if (state_q == S_WB) begin
      rf_wa = is_r ? rd : rt;
      rf_wd = is_lw ? mdr_q : alu_q;
      rf_we = (rf_wa != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sext_q  <= '0;
      tgt_q   <= '0;
      mdr_q   <= '0;
      alu_q   <= '0;
      zero_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= pc_q[ADDR_W-1:0];
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 32'd4;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q     <= rf_q[rs];
          b_q     <= rf_q[rt];
          sext_q  <= sext_d;
          tgt_q   <= pc_q + {sext_d[29:0], 2'b00};
          state_q <= legal ? S_EXEC : S_TRAP;
          trap_q  <= !legal;
        end
        S_EXEC: begin
          alu_q  <= alu_d;
          zero_q <= (alu_d == 32'd0);
          pc_q   <= br_pc_d;
          if (is_lw || is_sw) begin
            state_q <= S_MEM;
            req_q   <= 1'b1;
            we_q    <= is_sw;
            addr_q  <= alu_d[ADDR_W-1:0];
            wdata_q <= b_q;
          end else if (is_r || is_addi) begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            req_q <= 1'b0;
            if (is_lw) begin
              mdr_q   <= mem_rdata;
              state_q <= S_WB;
            end
          end
        end
        S_WB:   ;
        S_TRAP: ;
        default: state_q <= S_IDLE;
      endcase
      if (retire) begin
        if (run) begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          we_q    <= 1'b0;
          addr_q  <= nxt_pc_d[ADDR_W-1:0];
        end else begin
          state_q <= S_IDLE;
        end
      end
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign pc         = pc_q;
  assign alu_result = alu_q;
  assign flag_zero  = zero_q;
  assign state      = state_q;
  assign instr_done = retire;
  assign trap       = trap_q;

endmodule

// File: tb/tb_mips_multiciclo.sv
// Directed bench for mips_multiciclo: wait-state memory model,
// hand-assembled programs, per-instruction result and CPI checks.
module tb_mips_multiciclo;
  logic        clk = 1'b0;
  logic        rst, run, init_we;
  logic [4:0]  init_addr;
  logic [31:0] init_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc, alu_result;
  logic        flag_zero, instr_done, trap;
  logic [2:0]  state;

  mips_multiciclo dut (
    .clk(clk), .rst(rst), .run(run),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .alu_result(alu_result), .flag_zero(flag_zero),
    .state(state), .instr_done(instr_done), .trap(trap)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int prev_t = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [64];
  int          data_waits = 3;
  logic [31:0] hang_addr = 32'hFFFF_FFFF;
  int          wcnt = 0;
  int          req_cnt = 0;
  logic        hold_bad = 1'b0;
  logic [31:0] h_addr, h_wdata, d_addr, d_wdata;
  logic        h_we, d_we;
  int          d_len = 0;

  // memory responder: data accesses (DUT in MEM) see data_waits stalls
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cnt++;
        if (wcnt == 0) begin
          h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        end else if (mem_addr !== h_addr || mem_we !== h_we
                     || (mem_we && mem_wdata !== h_wdata)) begin
          hold_bad = 1'b1;
        end
        if (mem_addr != hang_addr
            && wcnt >= ((state == 3'd4) ? data_waits : 0)) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr[7:2]];
          if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
          if (state == 3'd4) begin
            d_len = wcnt + 1; d_we = mem_we;
            d_addr = mem_addr; d_wdata = mem_wdata;
          end
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic retire(input string tag, input int cpi);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 60) begin
      tick;
      n++;
      seen = instr_done;
    end
    chk({tag, "_done"}, {31'd0, seen}, 32'd1);
    chk({tag, "_cpi"}, cyc - prev_t, cpi);
    prev_t = cyc;
    tick;
  endtask

  task automatic init_wr(input logic [4:0] a, input logic [31:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    tick;
    init_we = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; run = 1'b0; init_we = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    rst = 1'b1; run = 1'b0; init_we = 1'b0;
    init_addr = '0; init_data = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0022_1820;  // add r3,r1,r2
    mem[1]  = 32'h0022_2022;  // sub r4,r1,r2
    mem[2]  = 32'hAC02_0008;  // sw  r2,8(r0)
    mem[3]  = 32'h8C05_0008;  // lw  r5,8(r0)
    mem[4]  = 32'h1021_FFFE;  // beq r1,r1,-2
    mem[5]  = 32'h0800_0010;  // j   0x40
    mem[16] = 32'hFC00_0000;  // opcode 0x3F
    do_reset;
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_alu", alu_result, 32'h0);
    chk("rst_zero", {31'd0, flag_zero}, 32'd0);
    chk("rst_done", {31'd0, instr_done}, 32'd0);

    init_wr(5'd1, 32'd5);
    init_wr(5'd2, 32'd7);
    init_wr(5'd0, 32'd9);
    tick;
    chk("idle_state", {29'd0, state}, 32'd0);
    chk("idle_req", {31'd0, mem_req}, 32'd0);

    run = 1'b1;
    prev_t = cyc;
    retire("add", 4);
    chk("add_alu", alu_result, 32'd12);
    chk("add_zero", {31'd0, flag_zero}, 32'd0);
    chk("add_pc", pc, 32'h04);
    retire("sub", 4);
    chk("sub_alu", alu_result, 32'hFFFF_FFFE);
    retire("sw", 7);
    chk("sw_len", d_len, 32'd4);
    chk("sw_we", {31'd0, d_we}, 32'd1);
    chk("sw_addr", d_addr, 32'h08);
    chk("sw_wdata", d_wdata, 32'd7);
    chk("sw_hold", {31'd0, hold_bad}, 32'd0);
    retire("lw", 8);
    chk("lw_alu", alu_result, 32'h08);
    chk("lw_we", {31'd0, d_we}, 32'd0);
    mem[3] = 32'h00A0_3820;   // add r7,r5,r0
    retire("beq_t", 3);
    chk("beq_t_pc", pc, 32'h0C);
    chk("beq_t_zero", {31'd0, flag_zero}, 32'd1);
    mem[4] = 32'h1022_0004;   // beq r1,r2,+4
    retire("add_r5", 4);
    chk("add_r5_alu", alu_result, 32'd7);
    chk("add_r5_pc", pc, 32'h10);
    retire("beq_n", 3);
    chk("beq_n_pc", pc, 32'h14);
    chk("beq_n_zero", {31'd0, flag_zero}, 32'd0);
    chk("beq_n_alu", alu_result, 32'hFFFF_FFFE);
    retire("j", 3);
    chk("j_pc", pc, 32'h40);

    n = 0;
    while (state != 3'd7 && n < 10) begin tick; n++; end
    chk("trap_state", {29'd0, state}, 32'd7);
    chk("trap_flag", {31'd0, trap}, 32'd1);
    chk("trap_pc", pc, 32'h44);
    r = req_cnt;
    repeat (10) tick;
    chk("trap_noreq", req_cnt, r);
    chk("trap_stays", {29'd0, state}, 32'd7);

    // second program after reset
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h2028_FFFA;  // addi r8,r1,-6
    mem[1] = 32'h0022_4824;  // and  r9,r1,r2
    mem[2] = 32'h0022_5025;  // or   r10,r1,r2
    mem[3] = 32'h0061_582A;  // slt  r11,r3,r1
    mem[4] = 32'h0023_602A;  // slt  r12,r1,r3
    mem[5] = 32'h0109_6820;  // add  r13,r8,r9
    mem[6] = 32'h0022_7020;  // add  r14,r1,r2
    mem[7] = 32'h01E0_8020;  // add  r16,r15,r0
    hang_addr = 32'h20;
    do_reset;
    chk("rst2_trap", {31'd0, trap}, 32'd0);
    chk("rst2_pc", pc, 32'h0);
    init_wr(5'd1, 32'd5);
    init_wr(5'd2, 32'd7);
    init_wr(5'd3, 32'hFFFF_FFFD);
    run = 1'b1;
    prev_t = cyc;
    retire("addi", 4);
    chk("addi_alu", alu_result, 32'hFFFF_FFFF);
    retire("and", 4);
    chk("and_alu", alu_result, 32'd5);
    retire("or", 4);
    chk("or_alu", alu_result, 32'd7);
    retire("slt1", 4);
    chk("slt1_alu", alu_result, 32'd1);
    retire("slt0", 4);
    chk("slt0_alu", alu_result, 32'd0);
    chk("slt0_zero", {31'd0, flag_zero}, 32'd1);
    retire("add_wb", 4);
    chk("add_wb_alu", alu_result, 32'd4);

    n = 0;
    while (state != 3'd3 && n < 10) begin tick; n++; end
    chk("exec_seen", {29'd0, state}, 32'd3);
    run = 1'b0;
    retire("stop", 4);
    chk("stop_state", {29'd0, state}, 32'd0);
    chk("stop_pc", pc, 32'h1C);
    chk("stop_alu", alu_result, 32'd12);
    init_wr(5'd15, 32'h0000_1234);
    tick;
    chk("stop_idle", {29'd0, state}, 32'd0);
    run = 1'b1;
    prev_t = cyc;
    retire("init_rd", 4);
    chk("init_rd_alu", alu_result, 32'h0000_1234);
    repeat (3) tick;
    chk("hang_state", {29'd0, state}, 32'd1);
    chk("hang_req", {31'd0, mem_req}, 32'd1);
    chk("hang_pc", pc, 32'h20);
    rst = 1'b1;
    tick;
    chk("midrst_state", {29'd0, state}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    run = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
